// File: rtl/demux8_event_counter_pkg.sv
// Shared constants and scan FSM state type for the demux8 event counter.
package demux8_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  localparam logic [CH_W-1:0] LAST_CH = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/demux8_event_counter_if.sv
// Count streaming port: one beat per channel, valid/ready flow control.
interface demux8_event_counter_if
  import demux8_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output out_valid,
    output out_ch,
    output out_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ch,
    input  out_cnt,
    output out_ready
  );

endinterface

// File: rtl/demux8_event_counter_ch_counter.sv
// One channel of saturating event counting with sticky flags and
// clear-by-subtraction so events arriving while a read is pending survive.
module ch_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_edge,
  input  logic             i_sub_en,
  input  logic [CNT_W-1:0] i_sub,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_active,
  output logic             o_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_ovf;

  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat;
  logic             w_active_nxt;
  logic             w_ovf_nxt;

  // Next count and flags: subtract the transferred snapshot, then add this cycle's edge.
  always_comb begin
    w_base       = r_cnt;
    w_cnt_nxt    = r_cnt;
    w_sat        = 1'b0;
    w_active_nxt = r_active;
    w_ovf_nxt    = r_ovf;

    if (i_sub_en) begin
      w_base = r_cnt - i_sub;
    end else begin
      w_base = r_cnt;
    end

    if (i_edge) begin
      if (w_base == CNT_MAX) begin
        w_cnt_nxt = w_base;
        w_sat     = 1'b1;
      end else begin
        w_cnt_nxt = w_base + CNT_ONE;
        w_sat     = 1'b0;
      end
    end else begin
      w_cnt_nxt = w_base;
      w_sat     = 1'b0;
    end

    if (i_sub_en) begin
      w_active_nxt = (w_cnt_nxt != CNT_ZERO);
      w_ovf_nxt    = w_sat;
    end else begin
      w_active_nxt = r_active | i_edge;
      w_ovf_nxt    = r_ovf | w_sat;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= CNT_ZERO;
      r_active <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_active <= w_active_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // The top snapshots the value the counter is about to take, not the stale one.
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_active  = r_active;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/demux8_event_counter.sv
// Rising-edge event counter for the eight demux outputs, with a scan FSM
// that streams every channel count out over a valid/ready port.
module demux8_event_counter
  import demux8_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit CLR_ON_READ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [NUM_CH-1:0]     i_y,
  input  logic                  i_scan_start,
  demux8_event_counter_if.master out_if,
  output logic                  o_busy,
  output logic [NUM_CH-1:0]     o_active,
  output logic [NUM_CH-1:0]     o_ovf
);

  localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]  CH_ONE   = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [NUM_CH-1:0] r_y_q;
  scan_state_e       r_state;
  logic [CH_W-1:0]   r_idx;
  logic              r_valid;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;

  logic [NUM_CH-1:0] w_edge;
  logic [NUM_CH-1:0] w_sub_en;
  logic [NUM_CH-1:0] w_active;
  logic [NUM_CH-1:0] w_ovf;
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [CH_W-1:0]   w_idx_nxt;
  logic              w_xfer;

  assign w_edge    = i_y & ~r_y_q & {NUM_CH{i_en}};
  assign w_xfer    = r_valid & out_if.out_ready;
  assign w_idx_nxt = r_idx + CH_ONE;

  // Clear request goes only to the channel whose beat is being accepted.
  always_comb begin
    w_sub_en = {NUM_CH{1'b0}};
    if (CLR_ON_READ && w_xfer) begin
      w_sub_en[r_idx] = 1'b1;
    end else begin
      w_sub_en = {NUM_CH{1'b0}};
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_counter #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_edge    (w_edge[g]),
      .i_sub_en  (w_sub_en[g]),
      .i_sub     (r_cnt),
      .o_cnt_nxt (w_cnt_nxt[g]),
      .o_active  (w_active[g]),
      .o_ovf     (w_ovf[g])
    );
  end

  // Edge-detect history tracks y even while counting is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q <= {NUM_CH{1'b0}};
    end else begin
      r_y_q <= i_y;
    end
  end

  // Scan FSM: one beat per channel, snapshot held stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= CH_ZERO;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_scan_start) begin
            r_state <= SCAN;
            r_idx   <= CH_ZERO;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= w_cnt_nxt[0];
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (w_xfer) begin
            if (r_idx == LAST_CH) begin
              r_state <= IDLE;
              r_idx   <= CH_ZERO;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= w_idx_nxt;
              r_cnt   <= w_cnt_nxt[w_idx_nxt];
            end
          end else begin
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= CH_ZERO;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_ch    = r_idx;
  assign out_if.out_cnt   = r_cnt;
  assign o_busy           = r_busy;
  assign o_active         = w_active;
  assign o_ovf            = w_ovf;

endmodule

// File: tb/tb_demux8_event_counter.sv
// Directed + random bench: two instances (8-bit and 4-bit counters) share stimulus
// and are compared against a per-channel saturating tally model.
module tb_demux8_event_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       scan_start;
  logic       ready;
  logic [7:0] y;
  logic       busy8, busy4;
  logic [7:0] act8, ovf8, act4, ovf4;

  always #5 clk = ~clk;

  demux8_event_counter_if #(.CNT_W(8)) if8 ();
  demux8_event_counter_if #(.CNT_W(4)) if4 ();
  assign if8.out_ready = ready;
  assign if4.out_ready = ready;

  demux8_event_counter #(.CNT_W(8), .CLR_ON_READ(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .i_en(en), .i_y(y), .i_scan_start(scan_start),
    .out_if(if8), .o_busy(busy8), .o_active(act8), .o_ovf(ovf8)
  );

  demux8_event_counter #(.CNT_W(4), .CLR_ON_READ(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .i_en(en), .i_y(y), .i_scan_start(scan_start),
    .out_if(if4), .o_busy(busy4), .o_active(act4), .o_ovf(ovf4)
  );

  int         m8 [8];
  int         m4 [8];
  bit         o8 [8];
  bit         o4 [8];
  logic [7:0] prev;
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 8; c++) begin
      m8[c] = 0; m4[c] = 0; o8[c] = 1'b0; o4[c] = 1'b0;
    end
    prev = 8'h00;
  endtask

  // Advance one clock and apply this cycle's rising edges to the model.
  task automatic tick();
    logic [7:0] e;
    e = y & ~prev & {8{en}};
    if (rst) e = 8'h00;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      prev = y;
      for (int c = 0; c < 8; c++) begin
        if (e[c]) begin
          if (m8[c] == 255) o8[c] = 1'b1; else m8[c]++;
          if (m4[c] == 15)  o4[c] = 1'b1; else m4[c]++;
        end
      end
    end
  endtask

  task automatic check_flags(input string tag);
    logic [7:0] ea8, eo8, ea4, eo4;
    for (int c = 0; c < 8; c++) begin
      ea8[c] = (m8[c] != 0); eo8[c] = o8[c];
      ea4[c] = (m4[c] != 0); eo4[c] = o4[c];
    end
    chk({tag, "_act8"}, {24'h0, act8}, {24'h0, ea8});
    chk({tag, "_ovf8"}, {24'h0, ovf8}, {24'h0, eo8});
    chk({tag, "_act4"}, {24'h0, act4}, {24'h0, ea4});
    chk({tag, "_ovf4"}, {24'h0, ovf4}, {24'h0, eo4});
  endtask

  // Full scan; optional stall on beat 0 with one y[0] pulse, optional re-pulse of scan_start.
  task automatic scan(input int stall0, input bit repulse);
    int s8, s4;
    ready = (stall0 == 0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      s8 = m8[c];
      s4 = m4[c];
      if (c == 0 && stall0 > 0) begin
        for (int k = 0; k < stall0; k++) begin
          chk("stall_valid", {31'h0, if8.out_valid}, 32'd1);
          chk("stall_ch", {29'h0, if8.out_ch}, 32'd0);
          chk("stall_cnt8", {24'h0, if8.out_cnt}, s8);
          chk("stall_cnt4", {28'h0, if4.out_cnt}, s4);
          y = (k == 1) ? 8'h01 : 8'h00;
          tick();
        end
        y = 8'h00;
        ready = 1'b1;
      end
      chk("beat_valid8", {31'h0, if8.out_valid}, 32'd1);
      chk("beat_valid4", {31'h0, if4.out_valid}, 32'd1);
      chk("beat_busy8", {31'h0, busy8}, 32'd1);
      chk("beat_ch8", {29'h0, if8.out_ch}, c);
      chk("beat_ch4", {29'h0, if4.out_ch}, c);
      chk("beat_cnt8", {24'h0, if8.out_cnt}, s8);
      chk("beat_cnt4", {28'h0, if4.out_cnt}, s4);
      if (repulse && c == 3) scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      m8[c] -= s8; m4[c] -= s4; o8[c] = 1'b0; o4[c] = 1'b0;
    end
    chk("end_valid8", {31'h0, if8.out_valid}, 32'd0);
    chk("end_busy8", {31'h0, busy8}, 32'd0);
    chk("end_busy4", {31'h0, busy4}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; scan_start = 1'b0; ready = 1'b0; y = 8'h00;
    model_reset();
    tick(); tick();
    chk("rst_valid", {31'h0, if8.out_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy8}, 32'd0);
    chk("rst_ch", {29'h0, if8.out_ch}, 32'd0);
    chk("rst_cnt", {24'h0, if8.out_cnt}, 32'd0);
    chk("rst_act", {24'h0, act8}, 32'd0);
    chk("rst_ovf", {24'h0, ovf8}, 32'd0);
    rst = 1'b0; en = 1'b1;
    tick();

    // Three isolated pulses on channel 5.
    for (int i = 0; i < 3; i++) begin
      y = 8'h20; tick(); y = 8'h00; tick(); tick();
    end
    chk("t1_act_pre", {24'h0, act8}, 32'h20);
    check_flags("t1");
    scan(0, 1'b0);
    chk("t1_act_post", {24'h0, act8}, 32'h00);

    // Level held high counts once.
    y = 8'h01;
    for (int i = 0; i < 10; i++) tick();
    y = 8'h00; tick();
    chk("t2_act_pre", {24'h0, act8}, 32'h01);
    scan(0, 1'b0);

    // Saturation on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      y = 8'h04; tick(); y = 8'h00; tick();
    end
    chk("t3_ovf4", {24'h0, ovf4}, 32'h04);
    chk("t3_ovf8", {24'h0, ovf8}, 32'h00);
    check_flags("t3");
    scan(0, 1'b0);
    chk("t3_ovf4_post", {24'h0, ovf4}, 32'h00);
    check_flags("t3_post");

    // Stall on channel 0 with an event during the stall, then re-read it.
    scan(5, 1'b0);
    chk("t4_act_mid", {24'h0, act8}, 32'h01);
    scan(0, 1'b0);

    // Asynchronous reset in the middle of a scan.
    y = 8'h9a; tick(); y = 8'h00; tick();
    check_flags("t5_pre");
    ready = 1'b1; scan_start = 1'b1; tick(); scan_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      m8[c] = 0; m4[c] = 0;
    end
    chk("t5_ch3", {29'h0, if8.out_ch}, 32'd3);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_valid", {31'h0, if8.out_valid}, 32'd0);
    chk("t5_busy", {31'h0, busy8}, 32'd0);
    chk("t5_act", {24'h0, act8}, 32'd0);
    chk("t5_ovf4", {24'h0, ovf4}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    scan(0, 1'b0);

    // Counting disabled, and scan_start re-pulsed mid-scan.
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y = 8'h80; tick(); y = 8'h00; tick();
    end
    en = 1'b1; tick();
    check_flags("t6");
    scan(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_idle_busy", {31'h0, busy8}, 32'd0);
      chk("t6_idle_valid", {31'h0, if8.out_valid}, 32'd0);
    end

    // Random traffic rounds.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 30; i++) begin
        y  = 8'($urandom);
        en = ($urandom_range(0, 3) != 0);
        tick();
      end
      y = 8'h00; en = 1'b1; tick();
      check_flags("rnd_pre");
      scan(0, 1'b0);
      check_flags("rnd_post");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
